// File: rtl/column_frame_loader_pkg.sv
// Shared definitions for the column frame loader: header layout, marker and FSM states.
package column_frame_loader_pkg;

    localparam logic [11:0] FRAME_MARKER = 12'hFAB;

    localparam int MARKER_MSB = 31;
    localparam int MARKER_LSB = 20;
    localparam int COL_MSB    = 15;
    localparam int COL_LSB    = 8;
    localparam int FRAME_MSB  = 7;
    localparam int FRAME_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2
    } state_e;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decoder: turns (column, frame, enable) into a single FrameStrobe pulse.
module frame_strobe_decoder #(
    parameter int NumCols         = 8,
    parameter int MaxFramesPerCol = 20
) (
    input  logic                               clk,
    input  logic                               srst,
    input  logic [7:0]                         col,
    input  logic [7:0]                         frame,
    input  logic                               en,
    output logic [NumCols*MaxFramesPerCol-1:0] strobe
);

    localparam int SW = NumCols * MaxFramesPerCol;

    logic [31:0]   idx;
    logic [SW-1:0] strobe_next;
    logic [SW-1:0] strobe_reg;

    assign idx = 32'(col) * 32'(MaxFramesPerCol) + 32'(frame);

    // An index beyond the strobe vector matches no bit, so the output stays zero.
    for (genvar gi = 0; gi < SW; gi++) begin : g_bit
        assign strobe_next[gi] = en && (idx == 32'(gi));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            strobe_reg <= '0;
        end else begin
            strobe_reg <= strobe_next;
        end
    end

    assign strobe = strobe_reg;

endmodule

// File: rtl/column_frame_loader.sv
// Parses a frame header from the word stream, gathers one word per row into FrameData,
// then fires one FrameStrobe bit for the addressed column/frame.
module column_frame_loader
    import column_frame_loader_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 16,
    parameter int NumCols         = 8
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [FrameBitsPerRow-1:0]          s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic                                err_clr,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                busy,
    output logic                                err_marker,
    output logic                                err_range,
    output logic [15:0]                         frames_written
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

    state_e                     state_reg, state_next;
    logic [RowW-1:0]            row_reg;
    logic [7:0]                 col_reg;
    logic [7:0]                 frame_reg;
    logic                       suppress_reg;
    logic                       err_marker_reg;
    logic                       err_range_reg;
    logic [15:0]                fw_reg;
    logic [FrameBitsPerRow-1:0] row_data_reg [NumRows];

    logic       accept, hdr_accept, hdr_good, marker_bad, range_bad;
    logic       load_we, last_row, strobe_en;
    logic [11:0] hdr_marker;
    logic [7:0]  hdr_col, hdr_frame;

    assign hdr_marker = s_data[MARKER_MSB:MARKER_LSB];
    assign hdr_col    = s_data[COL_MSB:COL_LSB];
    assign hdr_frame  = s_data[FRAME_MSB:FRAME_LSB];

    assign accept     = s_valid && s_ready;
    assign hdr_accept = accept && (state_reg == IDLE);
    assign marker_bad = hdr_accept && (hdr_marker != FRAME_MARKER);
    assign hdr_good   = hdr_accept && (hdr_marker == FRAME_MARKER);
    assign range_bad  = hdr_good && (({24'd0, hdr_col} >= 32'(NumCols)) ||
                                     ({24'd0, hdr_frame} >= 32'(MaxFramesPerCol)));
    assign load_we    = accept && (state_reg == LOAD);
    assign last_row   = (row_reg == RowW'(NumRows - 1));
    assign strobe_en  = load_we && last_row && !suppress_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (hdr_good) state_next = LOAD;
            LOAD:    if (load_we && last_row) state_next = STROBE;
            STROBE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready comes from registered state only; gating by RST keeps it low while in reset.
    always_comb begin
        s_ready = 1'b0;
        busy    = 1'b0;
        case (state_reg)
            IDLE:    s_ready = !RST;
            LOAD: begin
                s_ready = !RST;
                busy    = 1'b1;
            end
            STROBE:  busy = 1'b1;
            default: begin
                s_ready = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_reg        <= '0;
            col_reg        <= '0;
            frame_reg      <= '0;
            suppress_reg   <= 1'b0;
            err_marker_reg <= 1'b0;
            err_range_reg  <= 1'b0;
            fw_reg         <= '0;
        end else begin
            if (hdr_good) begin
                col_reg      <= hdr_col;
                frame_reg    <= hdr_frame;
                row_reg      <= '0;
                suppress_reg <= range_bad;
            end else if (load_we) begin
                row_reg <= row_reg + RowW'(1);
            end
            // A set event in the same cycle as err_clr takes priority.
            if (marker_bad)   err_marker_reg <= 1'b1;
            else if (err_clr) err_marker_reg <= 1'b0;
            if (range_bad)    err_range_reg  <= 1'b1;
            else if (err_clr) err_range_reg  <= 1'b0;
            if (strobe_en && (fw_reg != 16'hFFFF)) fw_reg <= fw_reg + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NumRows; gi++) begin : g_row
        always_ff @(posedge CLK) begin
            if (RST) begin
                row_data_reg[gi] <= '0;
            end else if (load_we && (row_reg == RowW'(gi))) begin
                row_data_reg[gi] <= s_data;
            end
        end
        assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = row_data_reg[gi];
    end

    frame_strobe_decoder #(
        .NumCols         (NumCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_strobe (
        .clk    (CLK),
        .srst   (RST),
        .col    (col_reg),
        .frame  (frame_reg),
        .en     (strobe_en),
        .strobe (FrameStrobe)
    );

    assign err_marker     = err_marker_reg;
    assign err_range      = err_range_reg;
    assign frames_written = fw_reg;

endmodule

// File: tb/tb_column_frame_loader.sv
// Directed bench for column_frame_loader with a 4-row, 4-column, 20-frame configuration.
module tb_column_frame_loader;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int MF = 20;
    localparam int W  = 32;
    localparam int DW = NR * W;
    localparam int SW = NC * MF;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          err_clr = 1'b0;
    logic [DW-1:0] FrameData;
    logic [SW-1:0] FrameStrobe;
    logic          busy, err_marker, err_range;
    logic [15:0]   frames_written;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int onehot_bad = 0;
    int consec_bad = 0;
    logic [SW-1:0] prev_strobe = '0;

    column_frame_loader #(
        .FrameBitsPerRow (W),
        .MaxFramesPerCol (MF),
        .NumRows         (NR),
        .NumCols         (NC)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .err_clr        (err_clr),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .busy           (busy),
        .err_marker     (err_marker),
        .err_range      (err_range),
        .frames_written (frames_written)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (FrameStrobe != '0) begin
            strobe_cnt++;
            if ($countones(FrameStrobe) != 1) onehot_bad++;
            if (prev_strobe != '0) consec_bad++;
        end
        prev_strobe = FrameStrobe;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] sbit(input int idx);
        logic [SW-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] pack(input logic [31:0] base);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*W +: W] = base + 32'(i);
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Holds the word until accepted; returns one cycle after the accepting edge.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!s_ready) check("send_timeout", 1'b0, 1'b1);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base, input bit gaps);
        $display("[TB] frame hdr=%h base=%h gaps=%0d", hdr, base, gaps);
        send(hdr);
        for (int i = 0; i < NR; i++) begin
            if (gaps) repeat ($urandom_range(3, 0)) step();
            send(base + 32'(i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, snap, bad_bits, bad_ready;
        logic [31:0] hdr;

        // Reset state
        RST = 1'b1;
        repeat (3) step();
        check("rst_ready", s_ready, 1'b0);
        check("rst_data", FrameData, '0);
        check("rst_strobe", FrameStrobe, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_errm", err_marker, 1'b0);
        check("rst_errr", err_range, 1'b0);
        check("rst_fw", frames_written, 16'd0);
        RST = 1'b0;
        step();
        check("idle_ready", s_ready, 1'b1);

        // Basic frame: column 2, frame 19 -> bit 59
        send_frame(32'hFAB00213, 32'hA000_0000, 1'b0);
        check("t1_strobe", FrameStrobe, sbit(59));
        check("t1_ready_strobe", s_ready, 1'b0);
        check("t1_busy", busy, 1'b1);
        step();
        check("t1_strobe_off", FrameStrobe, '0);
        check("t1_fw", frames_written, 16'd1);
        check("t1_data", FrameData, pack(32'hA000_0000));
        check("t1_ready_back", s_ready, 1'b1);

        // Bad marker, then a good frame, then clear
        $display("[TB] bad marker word 12300000");
        send(32'h1230_0000);
        check("t2_errm", err_marker, 1'b1);
        check("t2_idle", busy, 1'b0);
        send_frame(32'hFAB00101, 32'hB000_0000, 1'b0);
        check("t2_strobe", FrameStrobe, sbit(21));
        step();
        check("t2_fw", frames_written, 16'd2);
        check("t2_data", FrameData, pack(32'hB000_0000));
        check("t2_errm_sticky", err_marker, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t2_errm_clr", err_marker, 1'b0);

        // Set wins over simultaneous clear
        $display("[TB] bad marker word ABC00000 with err_clr");
        err_clr = 1'b1;
        send(32'hABC0_0000);
        err_clr = 1'b0;
        check("t2_set_wins", err_marker, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t2_clr2", err_marker, 1'b0);

        // Out-of-range column: payload consumed, no strobe
        send_frame(32'hFAB00500, 32'hC000_0000, 1'b0);
        check("t3_no_strobe", FrameStrobe, '0);
        step();
        check("t3_errr", err_range, 1'b1);
        check("t3_fw", frames_written, 16'd2);
        check("t3_data", FrameData, pack(32'hC000_0000));
        check("t3_idle", busy, 1'b0);
        // Out-of-range frame index (20)
        send_frame(32'hFAB00014, 32'hC100_0000, 1'b0);
        check("t3_no_strobe_f", FrameStrobe, '0);
        step();
        check("t3_fw_f", frames_written, 16'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t3_errr_clr", err_range, 1'b0);
        // Highest valid index: column 3, frame 19 -> bit 79
        send_frame(32'hFAB00313, 32'hE000_0000, 1'b0);
        check("t3_max_strobe", FrameStrobe, sbit(79));
        step();
        check("t3_max_fw", frames_written, 16'd3);
        check("t3_max_errr", err_range, 1'b0);

        // Random s_valid gaps
        send_frame(32'hFAB00213, 32'hA000_0000, 1'b1);
        check("t4_strobe", FrameStrobe, sbit(59));
        step();
        check("t4_data", FrameData, pack(32'hA000_0000));
        check("t4_strobe_off", FrameStrobe, '0);
        check("t4_fw", frames_written, 16'd4);
        check("t4_strobe_cnt", strobe_cnt, 4);

        // Reset in the middle of LOAD
        $display("[TB] reset after 2 data words");
        send(32'hFAB00213);
        send(32'hD000_0000);
        send(32'hD000_0001);
        s_data  = 32'hD000_0002;
        s_valid = 1'b1;
        RST     = 1'b1;
        step();
        check("t5_ready_rst", s_ready, 1'b0);
        step();
        check("t5_data", FrameData, '0);
        check("t5_strobe", FrameStrobe, '0);
        check("t5_fw", frames_written, 16'd0);
        RST     = 1'b0;
        s_valid = 1'b0;
        step();
        send_frame(32'hFAB00000, 32'hF000_0000, 1'b0);
        check("t5_hdr_strobe", FrameStrobe, sbit(0));
        step();
        check("t5_hdr_data", FrameData, pack(32'hF000_0000));
        check("t5_strobe_cnt", strobe_cnt, 5);

        // 1000 back-to-back frames
        $display("[TB] 1000 back-to-back frames");
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        step();
        snap      = strobe_cnt;
        bad_bits  = 0;
        bad_ready = 0;
        c0        = cyc;
        for (int i = 0; i < 1000; i++) begin
            hdr = {12'hFAB, 4'h0, 8'(i % NC), 8'(i % MF)};
            send(hdr);
            for (int j = 0; j < NR; j++) send(32'(i * 16 + j));
            if (FrameStrobe !== sbit((i % NC) * MF + (i % MF))) bad_bits++;
            if (s_ready !== 1'b0) bad_ready++;
        end
        c1 = cyc;
        check("t6_cycles", c1 - c0, 5999);
        step();
        check("t6_fw", frames_written, 16'd1000);
        check("t6_strobe_cnt", strobe_cnt - snap, 1000);
        check("t6_bad_bits", bad_bits, 0);
        check("t6_bad_ready", bad_ready, 0);
        check("onehot_bad", onehot_bad, 0);
        check("consec_bad", consec_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/column_frame_loader.md
# column_frame_loader

Configuration-frame sequencer that feeds the fabric's frame-based configuration network, loading the switch-matrix and BEL configuration bits of tiles such as terminal, CLB and IO tiles. It accepts a 32-bit word stream (valid/ready), parses a frame header, and gathers one data word per fabric row into the shared FrameData bus. It then fires exactly one FrameStrobe bit, selected by column and frame index, to latch that frame into every tile of the addressed column. It sits between the bitstream source (UART/SPI/ICAP front end) and the tile array.

## Interface
Parameters:
- FrameBitsPerRow, 32: bits per row slice of a frame; equals the stream word width.
- MaxFramesPerCol, 20: frames per column; valid frame index range is 0..MaxFramesPerCol-1.
- NumRows, 16: fabric rows; data words per frame.
- NumCols, 8: fabric columns; valid column index range is 0..NumCols-1.

Ports:
- CLK, in, 1: single clock.
- RST, in, 1: reset, synchronous, active-high.
- s_data, in, 32: stream word.
- s_valid, in, 1: word valid.
- s_ready, out, 1: loader accepts word; a transfer happens when s_valid and s_ready are both high.
- err_clr, in, 1: clears the sticky error flags.
- FrameData, out, NumRows*FrameBitsPerRow: row k occupies bits [k*32 +: 32].
- FrameStrobe, out, NumCols*MaxFramesPerCol: one-hot write pulse; bit index is col*MaxFramesPerCol + frame.
- busy, out, 1: high in LOAD or STROBE.
- err_marker, out, 1: sticky; set by a header word with a bad marker.
- err_range, out, 1: sticky; set by a header with an out-of-range column or frame index.
- frames_written, out, 16: count of strobes issued; saturates at 0xFFFF.

## Operation
- Header word fields: [31:20] marker, fixed at 12'hFAB; [19:16] reserved, ignored; [15:8] column; [7:0] frame.
- IDLE:
  - s_ready=1.
  - Accepted word with marker != 12'hFAB: word is dropped, err_marker is set, state stays IDLE.
  - Good marker: latch column and frame, set row counter to 0, go to LOAD.
  - Out-of-range column or frame: set err_range, set the internal suppress flag, still go to LOAD so the payload is consumed and stream framing is kept.
- LOAD:
  - s_ready=1.
  - Each accepted word is written to FrameData row[row counter], then the row counter increments.
  - Accepting the word at row NumRows-1 moves the block to STROBE.
  - When s_valid is low, the block waits with no timeout.
- STROBE (one cycle):
  - s_ready=0.
  - FrameStrobe bit is high unless suppressed; with suppress set, FrameStrobe stays all-zero.
  - frames_written increments only when a strobe actually fires, saturating at 0xFFFF.
  - Next state is IDLE.
- FrameData changes only on LOAD writes, so it is stable through the whole STROBE cycle. FrameData holds its last value in IDLE.
- err_clr clears both error flags. If err_clr and a set event occur in the same cycle, the set wins.
- Rows are fixed width: a frame has no partial-length form.

## Timing
- Reset values: state IDLE, s_ready=0 while RST is high, FrameData=0, FrameStrobe=0, busy=0, both error flags=0, frames_written=0, row counter=0, suppress=0.
- Reset during LOAD aborts the frame: no strobe fires and FrameData clears. The first accepted word after reset is treated as a header.
- s_ready is decoded combinationally from registered state only; it has no combinational dependence on s_valid.
- Last data word accepted at cycle t: FrameStrobe high in cycle t+1 only; s_ready=0 at t+1; s_ready=1 at t+2, when the next header can be accepted.
- Best-case throughput is NumRows+2 cycles per frame.
- FrameStrobe is registered, one-hot or zero, and never high for two consecutive cycles.

## Structure
- Shared package column_frame_loader_pkg holds:
  - FRAME_MARKER = 12'hFAB.
  - Header field bit positions.
  - State enum {IDLE, LOAD, STROBE}.
- Sub-module frame_strobe_decoder: takes column, frame and enable; produces the registered one-hot FrameStrobe. It is reused by any future multi-column loader.

## Test plan
Test configuration: NumRows=4, NumCols=4, MaxFramesPerCol=20.
- Header 0xFAB00213 then words A0..A3 with s_valid always high: FrameData = {A3,A2,A1,A0}; FrameStrobe bit 2*20+19=59 high for exactly one cycle, one cycle after A3; frames_written=1.
- Header 0x12300000: err_marker=1, no state change; a following good header loads normally; then err_clr drops err_marker to 0.
- Header 0xFAB00500 (column 5 ≥ NumCols) plus 4 data words: all words consumed, err_range=1, FrameStrobe stays 0, frames_written unchanged, FrameData updated.
- Random s_valid gaps during LOAD: FrameData is identical to the gap-free run, and the strobe fires one cycle after the final accepted word.
- RST asserted after 2 of 4 data words: FrameData=0, no strobe, s_ready=0 during reset; the next word after reset is parsed as a header.
- Back-to-back frames: s_ready=0 in the strobe cycle only; 1000 frames give frames_written=1000, with exactly one one-hot strobe each.
